// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order writeback queue feeding the integer regfile write port
//
// Purpose:
//   Accepts register write requests from the load unit (mem_*) and the ALU (alu_*),
//   keeps them in a small in-order queue, and retires one per cycle onto the regfile
//   write port (we3/wa3/wd3). A per-register pending bitmap is exported for hazard checks.
//   When both sources enqueue in the same cycle, the mem entry is the older of the two.
//   Writes to register 0 complete the handshake but are never stored.
//
// Optional feature (macro WB_FORWARD_EN):
//   Adds read-port lookups ra1/ra2 returning fwdN_hit/fwdN_data from the youngest
//   queued entry that targets the same register. Absent when the macro is undefined.
//
// Ports:
//   clk                 in   clock, all state updates on rising edge
//   reset               in   synchronous reset, active-high
//   mem_valid/ready     in/out load-unit request handshake
//   mem_addr/mem_data   in   load-unit destination register / data
//   alu_valid/ready     in/out ALU request handshake
//   alu_addr/alu_data   in   ALU destination register / data
//   wb_hold             in   1 = regfile port borrowed, do not retire this cycle
//   we3/wa3/wd3         out  regfile write enable / address / data
//   pending             out  bit r set while a queued entry targets register r
//   ra1/ra2             in   (WB_FORWARD_EN) lookup addresses
//   fwd1_hit/fwd2_hit   out  (WB_FORWARD_EN) a queued entry targets raN
//   fwd1_data/fwd2_data out  (WB_FORWARD_EN) data of the youngest matching entry

module wb_queue #(
  parameter int BANK_WIDTH = 5,
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [BANK_WIDTH-1:0]      mem_addr,
  input  logic [WIDTH-1:0]           mem_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [BANK_WIDTH-1:0]      alu_addr,
  input  logic [WIDTH-1:0]           alu_data,
  input  logic                       wb_hold,
  output logic                       we3,
  output logic [BANK_WIDTH-1:0]      wa3,
  output logic [WIDTH-1:0]           wd3,
  output logic [(1<<BANK_WIDTH)-1:0] pending
`ifdef WB_FORWARD_EN
  ,
  input  logic [BANK_WIDTH-1:0]      ra1,
  input  logic [BANK_WIDTH-1:0]      ra2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [WIDTH-1:0]           fwd1_data,
  output logic [WIDTH-1:0]           fwd2_data
`endif
);

  localparam int NREG  = 1 << BANK_WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH_M1 = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_DEPTH_M2 = CNT_W'(DEPTH - 2);

  // Entry storage. Payload is not reset: an entry only matters while its r_vld bit is set.
  logic [BANK_WIDTH-1:0] r_addr [DEPTH];
  logic [WIDTH-1:0]      r_data [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_mem_ready;
  logic                  w_alu_ready;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_mem_store;
  logic                  w_alu_store;
  logic [PTR_W-1:0]      w_alu_ptr;
  logic [DEPTH-1:0]      w_vld_next;
  logic [NREG-1:0]       w_pending;

  // Readiness looks only at the registered count, so a slot freed by this cycle's drain
  // is not reused until the next cycle. The ALU may take the last free slot only when the
  // load unit is not also asking for it.
  always_comb begin
    w_mem_ready = !reset && (r_count <= C_DEPTH_M1);
    w_alu_ready = !reset && ((r_count <= C_DEPTH_M2) ||
                             ((r_count == C_DEPTH_M1) && !mem_valid));
  end

  always_comb begin
    w_empty     = (r_count == '0);
    w_pop       = !reset && !w_empty && !wb_hold;
    w_mem_store = mem_valid && w_mem_ready && (mem_addr != '0);
    w_alu_store = alu_valid && w_alu_ready && (alu_addr != '0);
    // The ALU entry lands behind the mem entry when both are stored this cycle.
    w_alu_ptr   = r_wr_ptr + PTR_W'(w_mem_store);
  end

  // Valid bits: a popped slot is never the slot being written, since stores only go to
  // free slots and the head slot is occupied whenever a pop happens.
  always_comb begin
    w_vld_next = r_vld;
    if (w_pop)       w_vld_next[r_rd_ptr]  = 1'b0;
    if (w_mem_store) w_vld_next[r_wr_ptr]  = 1'b1;
    if (w_alu_store) w_vld_next[w_alu_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_mem_store) + PTR_W'(w_alu_store);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + CNT_W'(w_mem_store) + CNT_W'(w_alu_store) - CNT_W'(w_pop);
      r_vld    <= w_vld_next;
    end
  end

  // Stores are already blocked during reset through the ready terms.
  always_ff @(posedge clk) begin
    if (w_mem_store) begin
      r_addr[r_wr_ptr] <= mem_addr;
      r_data[r_wr_ptr] <= mem_data;
    end
    if (w_alu_store) begin
      r_addr[w_alu_ptr] <= alu_addr;
      r_data[w_alu_ptr] <= alu_data;
    end
  end

  // An entry stays pending through the cycle it is presented on we3 and clears once popped.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_pending[r_addr[i]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  always_comb begin
    mem_ready = w_mem_ready;
    alu_ready = w_alu_ready;
    we3       = w_pop;
    pending   = reset ? '0 : w_pending;
    if (reset || w_empty) begin
      wa3 = '0;
      wd3 = '0;
    end else begin
      wa3 = r_addr[r_rd_ptr];
      wd3 = r_data[r_rd_ptr];
    end
  end

`ifdef WB_FORWARD_EN
  logic [WIDTH:0]   w_fwd1;
  logic [WIDTH:0]   w_fwd2;
  logic [PTR_W-1:0] w_idx;

  // Walk from oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (r_vld[w_idx] && (ra1 != '0) && (r_addr[w_idx] == ra1))
        w_fwd1 = {1'b1, r_data[w_idx]};
      if (r_vld[w_idx] && (ra2 != '0) && (r_addr[w_idx] == ra2))
        w_fwd2 = {1'b1, r_data[w_idx]};
    end
  end

  always_comb begin
    fwd1_hit  = w_fwd1[WIDTH];
    fwd1_data = w_fwd1[WIDTH-1:0];
    fwd2_hit  = w_fwd2[WIDTH];
    fwd2_data = w_fwd2[WIDTH-1:0];
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - scoreboard bench for wb_queue
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid, wb_hold;
  logic        mem_ready, alu_ready, we3;
  logic [4:0]  mem_addr, alu_addr, wa3;
  logic [63:0] mem_data, alu_data, wd3;
  logic [31:0] pending;
`ifdef WB_FORWARD_EN
  logic [4:0]  ra1, ra2;
  logic        fwd1_hit, fwd2_hit;
  logic [63:0] fwd1_data, fwd2_data;
`endif

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_queue #(.BANK_WIDTH(5), .WIDTH(64), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .wb_hold(wb_hold), .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending)
`ifdef WB_FORWARD_EN
    , .ra1(ra1), .ra2(ra2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [63:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; drives one request cycle and returns just after the
  // edge that samples it. Expected readies are hand-computed by the caller.
  task automatic send(input bit mv, input logic [4:0] ma, input logic [63:0] md,
                      input bit av, input logic [4:0] aa, input logic [63:0] ad,
                      input bit emr, input bit ear);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    @(negedge clk);
    if (mv) chk("mem_ready", mem_ready, emr);
    if (av) chk("alu_ready", alu_ready, ear);
    if (mv && emr && ma != 5'd0) push(ma, md);
    if (av && ear && aa != 5'd0) push(aa, ad);
    cyc();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, ok, 1'b1);
  endtask

  // Monitor: every retired write must match the oldest expected entry.
  always @(negedge clk) begin
    ent_t e;
    if (reset) begin
      chk("reset_we3", we3, 1'b0);
      chk("reset_pending", pending, 32'h0);
    end else if (we3 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_wa3", wa3, 5'h0);
        chk("unexpected_write_we3", we3, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("wa3", wa3, e.a);
        chk("wd3", wd3, e.d);
      end
    end else begin
      chk("we3_known", we3, 1'b0);
      if (sb.size() == 0) begin
        chk("empty_wa3", wa3, 5'h0);
        chk("empty_wd3", wd3, 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wb_hold = 1'b0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
`ifdef WB_FORWARD_EN
    ra1 = '0; ra2 = '0;
`endif
    @(negedge clk);
    chk("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_mem_ready", mem_ready, 1'b1);
    chk("idle_alu_ready", alu_ready, 1'b1);
    chk("idle_pending", pending, 32'h0);
    cyc();

    // single ALU write, one-cycle latency
    send(0, 0, 0, 1, 5'd5, 64'hAB, 1, 1);
    @(negedge clk);
    chk("t1_we3", we3, 1'b1);
    chk("t1_pending", pending, 32'h0000_0020);
    cyc();
    @(negedge clk);
    chk("t1_we3_after", we3, 1'b0);
    chk("t1_pending_after", pending, 32'h0);
    cyc();

    // simultaneous mem + alu from empty: mem is older
    send(1, 5'd3, 64'd1, 1, 5'd4, 64'd2, 1, 1);
    wait_drain("t2_drain", 8);

    // fill under hold, full queue refuses both sources
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) send(0, 0, 0, 1, 5'(i), 64'h10 + 64'(i), 1, 1);
    @(negedge clk);
    chk("t3_alu_ready_full", alu_ready, 1'b0);
    chk("t3_mem_ready_full", mem_ready, 1'b0);
    chk("t3_pending", pending, 32'h0000_001E);
    chk("t3_hold_we3", we3, 1'b0);
    cyc();
    wb_hold = 1'b0;
    wait_drain("t3_drain", 10);

    // count==DEPTH-1 with both requesting: only mem gets the last slot
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 0, 0, 1, 5'(10 + i), 64'hA0 + 64'(i), 1, 1);
    send(1, 5'd13, 64'hD13, 1, 5'd14, 64'hE14, 1, 0);
    @(negedge clk);
    chk("t3b_pending", pending, 32'h0000_3C00);
    chk("t3b_mem_ready_full", mem_ready, 1'b0);
    cyc();
    wb_hold = 1'b0;
    wait_drain("t3b_drain", 10);

    // count==DEPTH-2 with both requesting: both accepted
    wb_hold = 1'b1;
    send(0, 0, 0, 1, 5'd20, 64'h20, 1, 1);
    send(0, 0, 0, 1, 5'd21, 64'h21, 1, 1);
    send(1, 5'd22, 64'h22, 1, 5'd23, 64'h23, 1, 1);
    @(negedge clk);
    chk("t3c_pending", pending, 32'h00F0_0000);
    cyc();
    wb_hold = 1'b0;
    wait_drain("t3c_drain", 10);

    // register 0 writes are accepted but never stored
    send(0, 0, 0, 1, 5'd0, 64'hFF, 1, 1);
    @(negedge clk);
    chk("t4_we3", we3, 1'b0);
    chk("t4_pending", pending, 32'h0);
    cyc();
    send(1, 5'd0, 64'hEE, 1, 5'd6, 64'h66, 1, 1);
    wait_drain("t4_drain", 6);

    // same register twice: retire oldest first, forward youngest
    wb_hold = 1'b1;
    send(0, 0, 0, 1, 5'd7, 64'd1, 1, 1);
    send(0, 0, 0, 1, 5'd7, 64'd2, 1, 1);
`ifdef WB_FORWARD_EN
    ra1 = 5'd7; ra2 = 5'd3;
`endif
    @(negedge clk);
    chk("t5_pending", pending, 32'h0000_0080);
`ifdef WB_FORWARD_EN
    chk("t5_fwd1_hit", fwd1_hit, 1'b1);
    chk("t5_fwd1_data", fwd1_data, 64'd2);
    chk("t5_fwd2_hit", fwd2_hit, 1'b0);
    chk("t5_fwd2_data", fwd2_data, 64'd0);
`endif
    cyc();
    wb_hold = 1'b0;
    wait_drain("t5_drain", 8);

    // reset discards queued entries
    wb_hold = 1'b1;
    for (int i = 1; i <= 3; i++) send(0, 0, 0, 1, 5'(i), 64'h60 + 64'(i), 1, 1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t6_rst_mem_ready", mem_ready, 1'b0);
    chk("t6_rst_alu_ready", alu_ready, 1'b0);
    cyc();
    reset = 1'b0;
    wb_hold = 1'b0;
    @(negedge clk);
    chk("t6_pending", pending, 32'h0);
    chk("t6_mem_ready", mem_ready, 1'b1);
    chk("t6_alu_ready", alu_ready, 1'b1);
    chk("t6_we3", we3, 1'b0);
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
